// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_pkg
// Description : Shared encodings for the multicycle ARM control FSM: state
//               enum, ALU control codes, condition codes, opcode classes and
//               datapath mux select values.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_pkg;

    // Controller states, one per datapath step of the multicycle machine
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    // ALUControl codes
    localparam logic [2:0] C_ALU_ADD = 3'b000;
    localparam logic [2:0] C_ALU_SUB = 3'b001;
    localparam logic [2:0] C_ALU_AND = 3'b010;
    localparam logic [2:0] C_ALU_ORR = 3'b011;

    // Data-processing cmd field values
    localparam logic [3:0] C_CMD_ADD = 4'b0100;
    localparam logic [3:0] C_CMD_SUB = 4'b0010;
    localparam logic [3:0] C_CMD_AND = 4'b0000;
    localparam logic [3:0] C_CMD_ORR = 4'b1100;

    // Op field classes
    localparam logic [1:0] C_OP_DP  = 2'b00;
    localparam logic [1:0] C_OP_MEM = 2'b01;
    localparam logic [1:0] C_OP_BR  = 2'b10;

    // Condition field values
    localparam logic [3:0] C_COND_EQ = 4'b0000;
    localparam logic [3:0] C_COND_NE = 4'b0001;
    localparam logic [3:0] C_COND_CS = 4'b0010;
    localparam logic [3:0] C_COND_CC = 4'b0011;
    localparam logic [3:0] C_COND_MI = 4'b0100;
    localparam logic [3:0] C_COND_PL = 4'b0101;
    localparam logic [3:0] C_COND_VS = 4'b0110;
    localparam logic [3:0] C_COND_VC = 4'b0111;
    localparam logic [3:0] C_COND_HI = 4'b1000;
    localparam logic [3:0] C_COND_LS = 4'b1001;
    localparam logic [3:0] C_COND_GE = 4'b1010;
    localparam logic [3:0] C_COND_LT = 4'b1011;
    localparam logic [3:0] C_COND_GT = 4'b1100;
    localparam logic [3:0] C_COND_LE = 4'b1101;
    localparam logic [3:0] C_COND_AL = 4'b1110;

    // Mux select values
    localparam logic [1:0] C_RES_ALUOUT    = 2'b00;
    localparam logic [1:0] C_RES_DATA      = 2'b01;
    localparam logic [1:0] C_RES_ALURESULT = 2'b10;
    localparam logic [1:0] C_SRCB_REG      = 2'b00;
    localparam logic [1:0] C_SRCB_IMM      = 2'b01;
    localparam logic [1:0] C_SRCB_FOUR     = 2'b10;

    // Map a data-processing cmd onto the ALU; unsupported commands run as ADD
    function automatic logic [2:0] decode_alu(input logic [3:0] cmd);
        case (cmd)
            C_CMD_ADD: decode_alu = C_ALU_ADD;
            C_CMD_SUB: decode_alu = C_ALU_SUB;
            C_CMD_AND: decode_alu = C_ALU_AND;
            C_CMD_ORR: decode_alu = C_ALU_ORR;
            default:   decode_alu = C_ALU_ADD;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/cond_check.sv
`default_nettype none
// ============================================================================
// Module      : cond_check
// Description : Combinational ARM condition-field evaluation against the
//               NZCV flags.
// Revision    : 1.0 - initial release
// ============================================================================
module cond_check
    import mc_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic w_n, w_z, w_c, w_v, w_ge;

    assign {w_n, w_z, w_c, w_v} = Flags;
    assign w_ge = (w_n == w_v);

    // Decode the condition field into a pass/fail bit
    always_comb begin
        case (Cond)
            C_COND_EQ: CondEx = w_z;
            C_COND_NE: CondEx = ~w_z;
            C_COND_CS: CondEx = w_c;
            C_COND_CC: CondEx = ~w_c;
            C_COND_MI: CondEx = w_n;
            C_COND_PL: CondEx = ~w_n;
            C_COND_VS: CondEx = w_v;
            C_COND_VC: CondEx = ~w_v;
            C_COND_HI: CondEx = w_c & ~w_z;
            C_COND_LS: CondEx = ~w_c | w_z;
            C_COND_GE: CondEx = w_ge;
            C_COND_LT: CondEx = ~w_ge;
            C_COND_GT: CondEx = ~w_z & w_ge;
            C_COND_LE: CondEx = w_z | ~w_ge;
            C_COND_AL: CondEx = 1'b1;
            default:   CondEx = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Control FSM for the multicycle ARM datapath. Sequences
//               fetch/decode/execute/writeback over 2-5 cycles, holds the
//               NZCV flags register and drives all enables and mux selects.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic [1:0]  ResultSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUControl,
    output logic [2:0]  ImmSrc,
    output logic [2:0]  RegSrc
);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_flags;
    logic        r_exec_pass;
    logic        w_condex;
    logic [1:0]  w_op;
    logic        w_i;
    logic        w_l;
    logic        w_s;
    logic [3:0]  w_cmd;
    logic [2:0]  w_alu_cmd;
    logic        w_is_exec;
    logic        w_unused;

    assign w_op      = Instr[27:26];
    assign w_i       = Instr[25];
    assign w_l       = Instr[20];
    assign w_s       = Instr[20];
    assign w_cmd     = Instr[24:21];
    assign w_alu_cmd = decode_alu(w_cmd);
    assign w_is_exec = (r_state == S_EXECR) || (r_state == S_EXECI);
    assign w_unused  = &{1'b0, Instr[19:0]};

    cond_check u_cond_check (
        .Cond   (Instr[31:28]),
        .Flags  (r_flags),
        .CondEx (w_condex)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Flags register plus the execute-stage condition result. ALUWB uses the
    // condition as it stood in EXEC, so an instruction's own flag update can
    // never cancel its register write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags     <= 4'b0000;
            r_exec_pass <= 1'b0;
        end else if (w_is_exec) begin
            r_exec_pass <= w_condex;
            if (w_s && w_condex) begin
                r_flags[3:2] <= ALUFlags[3:2];
                if ((w_alu_cmd == C_ALU_ADD) || (w_alu_cmd == C_ALU_SUB)) begin
                    r_flags[1:0] <= ALUFlags[1:0];
                end
            end
        end
    end

    // Next-state selection
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (w_op)
                    C_OP_MEM: w_next = S_MEMADR;
                    C_OP_DP:  w_next = w_i ? S_EXECI : S_EXECR;
                    C_OP_BR:  w_next = S_BRANCH;
                    default:  w_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_next = w_l ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = S_MEMWB;
            S_EXECR:  w_next = S_ALUWB;
            S_EXECI:  w_next = S_ALUWB;
            default:  w_next = S_FETCH;
        endcase
    end

    // Per-state datapath controls; reset blocks every write enable
    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = C_RES_ALUOUT;
        ALUSrcA    = 1'b0;
        ALUSrcB    = C_SRCB_REG;
        ALUControl = C_ALU_ADD;
        case (r_state)
            S_FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = C_SRCB_FOUR;
                ResultSrc = C_RES_ALURESULT;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = C_SRCB_FOUR;
                ResultSrc = C_RES_ALURESULT;
            end
            S_MEMADR: begin
                ALUSrcB = C_SRCB_IMM;
            end
            S_MEMRD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = w_condex;
            end
            S_MEMWB: begin
                ResultSrc = C_RES_DATA;
                RegWrite  = w_condex;
            end
            S_EXECR: begin
                ALUSrcB    = C_SRCB_REG;
                ALUControl = w_alu_cmd;
            end
            S_EXECI: begin
                ALUSrcB    = C_SRCB_IMM;
                ALUControl = w_alu_cmd;
            end
            S_ALUWB: begin
                ResultSrc = C_RES_ALUOUT;
                RegWrite  = r_exec_pass;
            end
            S_BRANCH: begin
                ALUSrcB   = C_SRCB_IMM;
                ResultSrc = C_RES_ALURESULT;
                PCWrite   = w_condex;
            end
            default: ;
        endcase
        if (reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
        end
    end

    // Immediate and register-port selects follow the instruction class
    always_comb begin
        ImmSrc = 3'b000;
        RegSrc = 3'b000;
        if (w_op == C_OP_BR) begin
            RegSrc = 3'b001;
            ImmSrc = 3'b010;
        end else if (w_op == C_OP_MEM) begin
            ImmSrc = 3'b001;
            RegSrc = w_l ? 3'b000 : 3'b010;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Self-checking bench for multicycle_controller. An
//               instruction-level model produces the expected control vector
//               for every cycle; a few literal spot values pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

    logic        clk;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0]  ResultSrc, ALUSrcB;
    logic [2:0]  ALUControl, ImmSrc, RegSrc;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector layout: [18]PCWrite [17]AdrSrc [16]MemWrite [15]IRWrite
    // [14]RegWrite [13:12]ResultSrc [11]ALUSrcA [10:9]ALUSrcB
    // [8:6]ALUControl [5:3]ImmSrc [2:0]RegSrc
    localparam logic [18:0] B_PCW  = 19'h40000;
    localparam logic [18:0] B_ADR  = 19'h20000;
    localparam logic [18:0] B_MW   = 19'h10000;
    localparam logic [18:0] B_RW   = 19'h04000;
    localparam logic [18:0] M_RS   = 19'h03000;
    localparam logic [18:0] M_ALU  = 19'h001C0;
    localparam logic [18:0] M_SRCB = 19'h00600;
    localparam logic [18:0] M_EN   = 19'h5C000;
    localparam logic [18:0] M_ALL  = 19'h7FFFF;

    logic [18:0] dv;
    assign dv = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                 ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc};

    logic        exp_valid, h_valid;
    logic [18:0] exp_vec, exp_mask, h_mask, h_val;
    logic [3:0]  m_flags;
    int          n_checks, n_fail, cyc;

    // Single compare point: model vector every cycle, plus any literal spot check
    always @(negedge clk) begin
        if (exp_valid) begin
            n_checks++;
            if (((dv ^ exp_vec) & exp_mask) !== 19'h0) begin
                n_fail++;
                $display("FAIL model cyc=%0d actual=%05h required=%05h mask=%05h",
                         cyc, dv, exp_vec, exp_mask);
            end
        end
        if (h_valid) begin
            n_checks++;
            if ((dv & h_mask) !== h_val) begin
                n_fail++;
                $display("FAIL spot cyc=%0d actual=%05h required=%05h mask=%05h",
                         cyc, dv & h_mask, h_val, h_mask);
            end
        end
    end

    // Condition evaluation from the architectural rule: pairs of codes are
    // a predicate and its complement; 1111 never passes.
    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, r;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0:    r = z;
            3'd1:    r = cf;
            3'd2:    r = n;
            3'd3:    r = v;
            3'd4:    r = cf & ~z;
            3'd5:    r = (n == v);
            3'd6:    r = ~z & (n == v);
            default: r = 1'b1;
        endcase
        cond_ok = (c == 4'hF) ? 1'b0 : (r ^ c[0]);
    endfunction

    function automatic logic [18:0] mk(input logic pcw, input logic adr,
        input logic mw, input logic irw, input logic rw, input logic [1:0] rs,
        input logic a, input logic [1:0] b, input logic [2:0] alu,
        input logic [5:0] ir);
        mk = {pcw, adr, mw, irw, rw, rs, a, b, alu, ir};
    endfunction

    // Run one instruction from FETCH; rst_step pulses reset on that step and
    // abandons the instruction; h_step attaches a literal spot check.
    task automatic run_instr(input logic [31:0] ins, input logic [3:0] alu,
                             input int rst_step, input int h_step,
                             input logic [18:0] hm, input logic [18:0] hv);
        logic [18:0] seq[$];
        logic [1:0]  op;
        logic [3:0]  cmd;
        logic [2:0]  aluc;
        logic [5:0]  ir;
        logic        pass;
        int          exec_step;
        op   = ins[27:26];
        cmd  = ins[24:21];
        case (cmd)
            4'b0100: aluc = 3'd0;
            4'b0010: aluc = 3'd1;
            4'b0000: aluc = 3'd2;
            4'b1100: aluc = 3'd3;
            default: aluc = 3'd0;
        endcase
        if (op == 2'b10)                 ir = {3'b010, 3'b001};
        else if (op == 2'b01 && !ins[20]) ir = {3'b001, 3'b010};
        else if (op == 2'b01)             ir = {3'b001, 3'b000};
        else                              ir = 6'b0;
        pass      = cond_ok(ins[31:28], m_flags);
        exec_step = -1;
        seq.push_back(mk(1, 0, 0, 1, 0, 2'b10, 1, 2'b10, 3'd0, ir));
        seq.push_back(mk(0, 0, 0, 0, 0, 2'b10, 1, 2'b10, 3'd0, ir));
        if (op == 2'b01) begin
            seq.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 3'd0, ir));
            if (ins[20]) begin
                seq.push_back(mk(0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 3'd0, ir));
                seq.push_back(mk(0, 0, 0, 0, pass, 2'b01, 0, 2'b00, 3'd0, ir));
            end else begin
                seq.push_back(mk(0, 1, pass, 0, 0, 2'b00, 0, 2'b00, 3'd0, ir));
            end
        end else if (op == 2'b00) begin
            exec_step = 2;
            seq.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, ins[25] ? 2'b01 : 2'b00, aluc, ir));
            seq.push_back(mk(0, 0, 0, 0, pass, 2'b00, 0, 2'b00, 3'd0, ir));
        end else if (op == 2'b10) begin
            seq.push_back(mk(pass, 0, 0, 0, 0, 2'b10, 0, 2'b01, 3'd0, ir));
        end
        for (int k = 0; k < seq.size(); k++) begin
            @(posedge clk);
            #1;
            reset    = (k == rst_step);
            Instr    = ins;
            ALUFlags = alu;
            exp_vec  = reset ? (seq[k] & ~M_EN) : seq[k];
            exp_mask = M_ALL;
            h_valid  = (k == h_step);
            h_mask   = hm;
            h_val    = hv;
            cyc++;
            if (k == exec_step && ins[20] && pass) begin
                m_flags[3:2] = alu[3:2];
                if (aluc <= 3'd1) m_flags[1:0] = alu[1:0];
            end
            if (k == rst_step) begin
                m_flags = 4'b0000;
                break;
            end
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        exp_valid = 1'b0;
        h_valid   = 1'b0;
        exp_vec   = '0;
        exp_mask  = '0;
        h_mask    = '0;
        h_val     = '0;
        m_flags   = 4'b0000;
        reset     = 1'b1;
        Instr     = 32'hDEADBEEF;
        ALUFlags  = 4'b1111;

        // Reset with garbage instruction: all write enables held low
        for (int r = 0; r < 3; r++) begin
            @(posedge clk);
            #1;
            exp_valid = 1'b1;
            exp_vec   = '0;
            exp_mask  = M_EN;
            cyc++;
        end

        // ADDS R1,R2,R3 setting Z; RegWrite in ALUWB
        run_instr(32'hE0921003, 4'b0100, -1, 3, B_RW, B_RW);
        // BEQ taken with Z=1
        run_instr(32'h0A000002, 4'b0000, -1, 2, B_PCW, B_PCW);
        // Clear flags, then BEQ not taken
        run_instr(32'hE0921003, 4'b0000, -1, -1, '0, '0);
        run_instr(32'h0A000002, 4'b0000, -1, 2, B_PCW, 19'h0);
        // LDR R0,[R1,#4]: Data result and register write in MEMWB
        run_instr(32'hE5910004, 4'b0000, -1, 4, B_RW | M_RS, B_RW | 19'h01000);
        // Set Z, then STRNE suppressed in MEMWR
        run_instr(32'hE0921003, 4'b0100, -1, -1, '0, '0);
        run_instr(32'h15810000, 4'b0000, -1, 3, B_MW | B_ADR, B_ADR);
        // ADDSEQ clears Z but still writes back; following BEQ not taken
        run_instr(32'h00921003, 4'b0000, -1, 3, B_RW, B_RW);
        run_instr(32'h0A000002, 4'b0000, -1, -1, '0, '0);
        // ANDS with ALUFlags 0011: CV must stay clear, so BCS not taken
        run_instr(32'hE0121003, 4'b0011, -1, 2, M_ALU, 19'h00080);
        run_instr(32'h2A000002, 4'b0000, -1, 2, B_PCW, 19'h0);
        // ORRS immediate sets N; BMI taken
        run_instr(32'hE3921005, 4'b1000, -1, 2, M_ALU | M_SRCB, 19'h002C0);
        run_instr(32'h4A000002, 4'b0000, -1, 2, B_PCW, B_PCW);
        // SUBS sets C; BCS taken
        run_instr(32'hE0521003, 4'b0010, -1, 2, M_ALU, 19'h00040);
        run_instr(32'h2A000002, 4'b0000, -1, -1, '0, '0);
        // EOR decodes as ADD; cond 1111 never writes; undefined op is 2 cycles
        run_instr(32'hE0221003, 4'b0000, -1, 2, M_ALU, 19'h0);
        run_instr(32'hF0821003, 4'b0000, -1, 3, B_RW, 19'h0);
        run_instr(32'hEC000000, 4'b0000, -1, -1, '0, '0);
        // LDR abandoned by reset in MEMWB, then resume from FETCH
        run_instr(32'hE5910004, 4'b0000, 4, 4, B_RW, 19'h0);
        run_instr(32'h0A000002, 4'b0000, -1, -1, '0, '0);
        run_instr(32'hE0921003, 4'b1001, -1, -1, '0, '0);
        // Flags now N=1,V=1: GE taken
        run_instr(32'hAA000002, 4'b0000, -1, 2, B_PCW, B_PCW);

        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        h_valid   = 1'b0;
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
